// File: rtl/lsu_ctrl.sv
// RV32I load/store controller for a word-organised data memory: byte/halfword
// extraction with sign/zero extension on loads, read-modify-write for sub-word stores.
module lsu_ctrl #(
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_store,
    input  logic [2:0]        req_funct3,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [31:0]       req_wdata,
    output logic              resp_valid,
    output logic [31:0]       resp_rdata,
    output logic              resp_err,
    output logic              mem_read,
    output logic              mem_write,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    input  logic [31:0]       mem_rdata
);

    typedef enum logic [1:0] {IDLE, READ, WRITE, RESP} state_t;

    state_t      state_r;
    logic        store_r;
    logic [2:0]  funct3_r;
    logic [1:0]  lane_r;
    logic [31:0] wdata_r;
    logic        req_bad_s;

    // Illegal funct3 for the direction, or an access not naturally aligned.
    function automatic logic is_bad(input logic st, input logic [2:0] f3, input logic [1:0] a);
        logic bad;
        case (f3)
            3'b000:         bad = 1'b0;
            3'b001:         bad = a[0];
            3'b010:         bad = (a != 2'b00);
            3'b100, 3'b101: bad = st;
            default:        bad = 1'b1;
        endcase
        return bad;
    endfunction

    function automatic logic [31:0] load_extract(input logic [31:0] w, input logic [2:0] f3,
                                                 input logic [1:0] a);
        logic [7:0]  b;
        logic [15:0] h;
        logic [31:0] r;
        case (a)
            2'd0:    b = w[7:0];
            2'd1:    b = w[15:8];
            2'd2:    b = w[23:16];
            default: b = w[31:24];
        endcase
        h = a[1] ? w[31:16] : w[15:0];
        case (f3)
            3'b000:  r = {{24{b[7]}}, b};
            3'b001:  r = {{16{h[15]}}, h};
            3'b010:  r = w;
            3'b100:  r = {24'd0, b};
            3'b101:  r = {16'd0, h};
            default: r = 32'd0;
        endcase
        return r;
    endfunction

    // Replace only the addressed lane of the word read back from memory.
    function automatic logic [31:0] store_merge(input logic [31:0] w, input logic [2:0] f3,
                                                input logic [1:0] a, input logic [31:0] wd);
        logic [31:0] m;
        m = w;
        case (f3)
            3'b000: begin
                case (a)
                    2'd0:    m[7:0]   = wd[7:0];
                    2'd1:    m[15:8]  = wd[7:0];
                    2'd2:    m[23:16] = wd[7:0];
                    default: m[31:24] = wd[7:0];
                endcase
            end
            3'b001: begin
                if (a[1]) m[31:16] = wd[15:0];
                else      m[15:0]  = wd[15:0];
            end
            default: m = wd;
        endcase
        return m;
    endfunction

    assign req_bad_s = is_bad(req_store, req_funct3, req_addr[1:0]);

    // Transaction FSM; every port output is a register updated here.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r    <= IDLE;
            store_r    <= 1'b0;
            funct3_r   <= 3'd0;
            lane_r     <= 2'd0;
            wdata_r    <= 32'd0;
            req_ready  <= 1'b1;
            resp_valid <= 1'b0;
            resp_err   <= 1'b0;
            resp_rdata <= 32'd0;
            mem_read   <= 1'b0;
            mem_write  <= 1'b0;
            mem_addr   <= {ADDR_W{1'b0}};
            mem_wdata  <= 32'd0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (req_valid) begin
                        store_r   <= req_store;
                        funct3_r  <= req_funct3;
                        lane_r    <= req_addr[1:0];
                        wdata_r   <= req_wdata;
                        req_ready <= 1'b0;
                        mem_addr  <= {req_addr[ADDR_W-1:2], 2'b00};
                        if (req_bad_s) begin
                            state_r    <= RESP;
                            resp_valid <= 1'b1;
                            resp_err   <= 1'b1;
                            resp_rdata <= 32'd0;
                        end else if (req_store && (req_funct3 == 3'b010)) begin
                            state_r   <= WRITE;
                            mem_write <= 1'b1;
                            mem_wdata <= req_wdata;
                        end else begin
                            state_r  <= READ;
                            mem_read <= 1'b1;
                        end
                    end else begin
                        state_r <= IDLE;
                    end
                end
                READ: begin
                    mem_read <= 1'b0;
                    if (store_r) begin
                        state_r   <= WRITE;
                        mem_write <= 1'b1;
                        mem_wdata <= store_merge(mem_rdata, funct3_r, lane_r, wdata_r);
                    end else begin
                        state_r    <= RESP;
                        resp_valid <= 1'b1;
                        resp_err   <= 1'b0;
                        resp_rdata <= load_extract(mem_rdata, funct3_r, lane_r);
                    end
                end
                WRITE: begin
                    mem_write  <= 1'b0;
                    state_r    <= RESP;
                    resp_valid <= 1'b1;
                    resp_err   <= 1'b0;
                    resp_rdata <= 32'd0;
                end
                RESP: begin
                    state_r    <= IDLE;
                    resp_valid <= 1'b0;
                    resp_err   <= 1'b0;
                    req_ready  <= 1'b1;
                    mem_addr   <= {ADDR_W{1'b0}};
                    mem_wdata  <= 32'd0;
                end
                default: begin
                    state_r    <= IDLE;
                    resp_valid <= 1'b0;
                    resp_err   <= 1'b0;
                    req_ready  <= 1'b1;
                    mem_read   <= 1'b0;
                    mem_write  <= 1'b0;
                    mem_addr   <= {ADDR_W{1'b0}};
                    mem_wdata  <= 32'd0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_lsu_ctrl.sv
// Directed bench for lsu_ctrl: 16-word memory model, hand-computed expected values.
module tb_lsu_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_store = 1'b0;
    logic [2:0]  req_funct3 = 3'd0;
    logic [31:0] req_addr = 32'd0;
    logic [31:0] req_wdata = 32'd0;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic        mem_read;
    logic        mem_write;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;

    logic [31:0] mem [0:15] = '{32'h0, 32'h8070_60F0, 32'h0, 32'h1122_3344,
                                32'h0, 32'h5566_7788, 32'h0, 32'h0,
                                32'h0, 32'h0, 32'h0, 32'h0,
                                32'h0, 32'h0, 32'h0, 32'h0};

    int          rd_cnt = 0;
    int          wr_cnt = 0;
    int          both_cnt = 0;
    logic [31:0] wr_addr = 32'd0;
    logic [31:0] wr_data = 32'd0;

    int          pass_cnt = 0;
    int          total_cnt = 0;

    logic [31:0] r_rdata;
    logic        r_err;
    int          r_lat;
    int          r_rd;
    int          r_wr;
    logic        r_vgone;

    lsu_ctrl #(.ADDR_W(32)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_store(req_store),
        .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
        .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
        .mem_read(mem_read), .mem_write(mem_write), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    assign mem_rdata = mem[mem_addr[5:2]];

    // Memory model and bus activity monitor.
    always @(posedge clk) begin
        if (mem_read) rd_cnt <= rd_cnt + 1;
        if (mem_write) begin
            wr_cnt  <= wr_cnt + 1;
            wr_addr <= mem_addr;
            wr_data <= mem_wdata;
            mem[mem_addr[5:2]] <= mem_wdata;
        end
        if (mem_read && mem_write) both_cnt <= both_cnt + 1;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total_cnt++;
        assert (obs === exp) pass_cnt++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    task automatic do_req(input logic st, input logic [2:0] f3, input logic [31:0] a,
                          input logic [31:0] wd);
        int rd0, wr0, lat;
        @(negedge clk);
        req_valid = 1'b1; req_store = st; req_funct3 = f3; req_addr = a; req_wdata = wd;
        rd0 = rd_cnt; wr0 = wr_cnt;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0; req_store = ~st; req_addr = 32'h3C; req_wdata = 32'h5A5A_5A5A;
        lat = 1;
        while (!resp_valid && lat < 10) begin
            @(posedge clk); @(negedge clk); lat++;
        end
        r_rdata = resp_rdata; r_err = resp_err;
        r_lat = resp_valid ? lat : 99;
        @(posedge clk); @(negedge clk);
        r_vgone = resp_valid;
        r_rd = rd_cnt - rd0; r_wr = wr_cnt - wr0;
    endtask

    initial begin
        int acc, resp_n, ready_in_resp;
        int resp_cyc [0:3];
        logic will_acc;

        // Reset state
        #12;
        chk("rst_req_ready", 32'(req_ready), 32'd1);
        chk("rst_resp", {29'd0, resp_valid, resp_err, mem_read}, 32'd0);
        chk("rst_resp_rdata", resp_rdata, 32'd0);
        chk("rst_mem_write", 32'(mem_write), 32'd0);
        chk("rst_mem_addr", mem_addr, 32'd0);
        chk("rst_mem_wdata", mem_wdata, 32'd0);
        @(negedge clk); rst_n = 1'b1;

        // Loads from word 0x4 = 0x807060F0
        do_req(1'b0, 3'b000, 32'h4, 32'd0);
        chk("lb_data", r_rdata, 32'hFFFF_FFF0);
        chk("lb_lat", 32'(r_lat), 32'd2);
        chk("lb_err", 32'(r_err), 32'd0);
        chk("lb_rd_cnt", 32'(r_rd), 32'd1);
        chk("lb_wr_cnt", 32'(r_wr), 32'd0);
        chk("lb_one_pulse", 32'(r_vgone), 32'd0);
        do_req(1'b0, 3'b100, 32'h7, 32'd0);
        chk("lbu_data", r_rdata, 32'h0000_0080);
        do_req(1'b0, 3'b001, 32'h6, 32'd0);
        chk("lh_data", r_rdata, 32'hFFFF_8070);
        do_req(1'b0, 3'b101, 32'h4, 32'd0);
        chk("lhu_data", r_rdata, 32'h0000_60F0);

        // Word store then load back
        do_req(1'b1, 3'b010, 32'h8, 32'hDEAD_BEEF);
        chk("sw_lat", 32'(r_lat), 32'd2);
        chk("sw_wr_cnt", 32'(r_wr), 32'd1);
        chk("sw_rd_cnt", 32'(r_rd), 32'd0);
        chk("sw_addr", wr_addr, 32'h8);
        chk("sw_wdata", wr_data, 32'hDEAD_BEEF);
        chk("sw_rdata_zero", r_rdata, 32'd0);
        do_req(1'b0, 3'b010, 32'h8, 32'd0);
        chk("lw_data", r_rdata, 32'hDEAD_BEEF);
        chk("lw_err", 32'(r_err), 32'd0);
        repeat (3) @(negedge clk);
        chk("rdata_hold", resp_rdata, 32'hDEAD_BEEF);

        // Sub-word read-modify-write on word 0xC = 0x11223344
        do_req(1'b1, 3'b000, 32'hE, 32'h0000_00AA);
        chk("sb_lat", 32'(r_lat), 32'd3);
        chk("sb_rd_cnt", 32'(r_rd), 32'd1);
        chk("sb_wr_cnt", 32'(r_wr), 32'd1);
        chk("sb_wdata", wr_data, 32'h11AA_3344);
        chk("sb_addr", wr_addr, 32'hC);
        do_req(1'b1, 3'b001, 32'hC, 32'h1234_BEEF);
        chk("sh_wdata", wr_data, 32'h11AA_BEEF);
        chk("sh_mem", mem[3], 32'h11AA_BEEF);

        // Error cases; preceding load leaves 0x80 in resp_rdata
        do_req(1'b0, 3'b100, 32'h7, 32'd0);
        do_req(1'b0, 3'b010, 32'h5, 32'd0);
        chk("lw_mis_err", 32'(r_err), 32'd1);
        chk("lw_mis_rdata", r_rdata, 32'd0);
        chk("lw_mis_lat", 32'(r_lat), 32'd1);
        chk("lw_mis_bus", 32'(r_rd + r_wr), 32'd0);
        do_req(1'b1, 3'b001, 32'h3, 32'h0000_FFFF);
        chk("sh_mis_err", 32'(r_err), 32'd1);
        chk("sh_mis_bus", 32'(r_rd + r_wr), 32'd0);
        do_req(1'b0, 3'b011, 32'h4, 32'd0);
        chk("f3_ill_err", 32'(r_err), 32'd1);
        chk("f3_ill_lat", 32'(r_lat), 32'd1);
        chk("f3_ill_bus", 32'(r_rd + r_wr), 32'd0);
        chk("err_mem0", mem[0], 32'd0);
        chk("err_mem1", mem[1], 32'h8070_60F0);

        // Four SWs with req_valid held high
        @(negedge clk);
        acc = 0; resp_n = 0; ready_in_resp = 0;
        req_valid = 1'b1; req_store = 1'b1; req_funct3 = 3'b010;
        req_addr = 32'h20; req_wdata = 32'hA000_0000;
        will_acc = req_ready;
        for (int c = 0; c < 40 && resp_n < 4; c++) begin
            @(posedge clk);
            @(negedge clk);
            if (will_acc) begin
                acc++;
                if (acc < 4) begin
                    req_addr = 32'h20 + 32'(acc * 4);
                    req_wdata = 32'hA000_0000 + 32'(acc);
                end else begin
                    req_valid = 1'b0;
                end
            end
            if (resp_valid) begin
                resp_cyc[resp_n] = c;
                resp_n++;
                if (req_ready) ready_in_resp++;
            end
            will_acc = req_ready && req_valid;
        end
        repeat (2) @(negedge clk);
        chk("b2b_accepts", 32'(acc), 32'd4);
        chk("b2b_resps", 32'(resp_n), 32'd4);
        chk("b2b_ready_busy", 32'(ready_in_resp), 32'd0);
        chk("b2b_gap01", 32'(resp_cyc[1] - resp_cyc[0]), 32'd3);
        chk("b2b_gap23", 32'(resp_cyc[3] - resp_cyc[2]), 32'd3);
        chk("b2b_mem8", mem[8], 32'hA000_0000);
        chk("b2b_mem11", mem[11], 32'hA000_0003);
        chk("never_both", 32'(both_cnt), 32'd0);

        // Reset asserted while an SB is in READ
        @(negedge clk);
        req_valid = 1'b1; req_store = 1'b1; req_funct3 = 3'b000;
        req_addr = 32'h15; req_wdata = 32'h99;
        r_wr = wr_cnt;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        chk("rr_in_read", 32'(mem_read), 32'd1);
        #1 rst_n = 1'b0;
        #1;
        chk("rr_outputs", {28'd0, mem_read, mem_write, resp_valid, req_ready}, 32'd1);
        chk("rr_mem_addr", mem_addr, 32'd0);
        repeat (2) @(negedge clk);
        chk("rr_no_write", 32'(wr_cnt - r_wr), 32'd0);
        chk("rr_mem5", mem[5], 32'h5566_7788);
        rst_n = 1'b1;
        do_req(1'b0, 3'b010, 32'h14, 32'd0);
        chk("rr_after_lw", r_rdata, 32'h5566_7788);
        chk("rr_after_lat", 32'(r_lat), 32'd2);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
